// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - token codes, builder FSM states and error bit positions
package calc_pkg;

   // Button codes as they appear in the token store
   typedef enum logic [7:0] {
      TOK_DIG0 = 8'd0,
      TOK_DIG1 = 8'd1,
      TOK_DIG2 = 8'd2,
      TOK_DIG3 = 8'd3,
      TOK_DIG4 = 8'd4,
      TOK_DIG5 = 8'd5,
      TOK_DIG6 = 8'd6,
      TOK_DIG7 = 8'd7,
      TOK_DIG8 = 8'd8,
      TOK_DIG9 = 8'd9,
      TOK_MUL  = 8'd12,
      TOK_LP   = 8'd14,
      TOK_RP   = 8'd15,
      TOK_DOT  = 8'd16,
      TOK_PI   = 8'd18,
      TOK_SIN  = 8'd23
   } token_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_PAD,
      ST_FINISH,
      ST_DONE
   } state_e;

   // Bit positions inside errCode
   localparam int ERR_DOT  = 0;
   localparam int ERR_OVF  = 1;
   localparam int ERR_FULL = 2;

endpackage

// File: rtl/sat_mac10.sv
// rtl/sat_mac10.sv - saturating acc*10+digit for the number accumulator
module sat_mac10 #(
   parameter int PW = 41
) (
   input  logic [PW-1:0] acc_i,
   input  logic [3:0]    digit_i,
   output logic [PW-1:0] result_o,
   output logic          sat_o
);

   logic [PW+3:0] acc_w;
   logic [PW+3:0] dig_w;
   logic [PW+3:0] sum_w;

   // Four guard bits hold acc*10+9 exactly, so any set guard bit means the payload range is exceeded
   always_comb begin
      acc_w    = {4'b0000, acc_i};
      dig_w    = {{PW{1'b0}}, digit_i};
      sum_w    = (acc_w << 3) + (acc_w << 1) + dig_w;
      sat_o    = |sum_w[PW+3:PW];
      result_o = sat_o ? {PW{1'b1}} : sum_w[PW-1:0];
   end

endmodule

// File: rtl/token_num_builder.sv
// rtl/token_num_builder.sv - merges digit/dot runs and pi into scaled numbers, passes operators through
module token_num_builder
   import calc_pkg::*;
#(
   parameter int DEPTH       = 20,
   parameter int WIDTH       = 8,
   parameter int NEWWIDTH    = 42,
   parameter int FRAC_DIGITS = 4,
   parameter int PI_SCALED   = 31416,
   localparam int AW         = $clog2(DEPTH),
   localparam int LW         = $clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [LW-1:0]       len,
   output logic [AW-1:0]       rdAddr,
   input  logic [WIDTH-1:0]    rdData,
   output logic                wrEn,
   output logic [AW-1:0]       wrAddr,
   output logic [NEWWIDTH-1:0] wrData,
   output logic [LW-1:0]       outLen,
   output logic                busy,
   output logic                done,
   output logic [2:0]          errCode
);

   localparam int PW = NEWWIDTH - 1;
   localparam int FW = $clog2(FRAC_DIGITS + 1);

   state_e            state_q, state_d;
   logic [LW-1:0]     idx_q, idx_d;
   logic [LW-1:0]     out_idx_q, out_idx_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     out_len_q, out_len_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic              in_num_q, in_num_d;
   logic              seen_dot_q, seen_dot_d;
   logic [FW-1:0]     frac_q, frac_d;
   logic [2:0]        err_q, err_d;

   logic              wr_req;
   logic [NEWWIDTH-1:0] wr_entry;
   logic [3:0]        mac_digit;
   logic [PW-1:0]     mac_res;
   logic              mac_sat;
   logic              tok_digit, tok_dot, tok_pi;

   assign tok_digit = rdData <= WIDTH'(TOK_DIG9);
   assign tok_dot   = rdData == WIDTH'(TOK_DOT);
   assign tok_pi    = rdData == WIDTH'(TOK_PI);
   // PAD reuses the same multiplier with a zero digit to shift in trailing decimal places
   assign mac_digit = (state_q == ST_PAD) ? 4'd0 : rdData[3:0];

   sat_mac10 #(.PW(PW)) u_mac (
      .acc_i    (acc_q),
      .digit_i  (mac_digit),
      .result_o (mac_res),
      .sat_o    (mac_sat)
   );

   assign rdAddr  = idx_q[AW-1:0];
   assign wrAddr  = out_idx_q[AW-1:0];
   assign wrData  = wr_entry;
   assign outLen  = out_len_q;
   assign errCode = err_q;
   assign busy    = state_q != ST_IDLE;
   assign done    = state_q == ST_DONE;

   // Next-state logic: token scan, number flush/padding, and the output write port
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      out_idx_d  = out_idx_q;
      len_d      = len_q;
      out_len_d  = out_len_q;
      acc_d      = acc_q;
      in_num_d   = in_num_q;
      seen_dot_d = seen_dot_q;
      frac_d     = frac_q;
      err_d      = err_q;
      wr_req     = 1'b0;
      wr_entry   = '0;
      wrEn       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               idx_d      = '0;
               out_idx_d  = '0;
               err_d      = '0;
               acc_d      = '0;
               in_num_d   = 1'b0;
               seen_dot_d = 1'b0;
               frac_d     = '0;
               len_d      = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
            end
         end
         ST_SCAN: begin
            if (idx_q == len_q) begin
               state_d = in_num_q ? ST_PAD : ST_FINISH;
            end else if (tok_digit) begin
               in_num_d = 1'b1;
               idx_d    = idx_q + 1'b1;
               // Digits beyond the fixed precision are truncated, not rounded
               if (!seen_dot_q || frac_q < FW'(FRAC_DIGITS)) begin
                  acc_d = mac_res;
                  if (mac_sat) err_d[ERR_OVF] = 1'b1;
                  if (seen_dot_q) frac_d = frac_q + 1'b1;
               end
            end else if (tok_dot) begin
               in_num_d = 1'b1;
               idx_d    = idx_q + 1'b1;
               if (seen_dot_q) err_d[ERR_DOT] = 1'b1;
               else seen_dot_d = 1'b1;
            end else if (in_num_q) begin
               // Flush the pending number first; this token is rescanned afterwards
               state_d = ST_PAD;
            end else if (tok_pi) begin
               wr_req   = 1'b1;
               wr_entry = {1'b1, PW'(PI_SCALED)};
               idx_d    = idx_q + 1'b1;
            end else begin
               wr_req   = 1'b1;
               wr_entry = {1'b0, PW'(rdData)};
               idx_d    = idx_q + 1'b1;
            end
         end
         ST_PAD: begin
            if (frac_q == FW'(FRAC_DIGITS)) begin
               wr_req     = 1'b1;
               wr_entry   = {1'b1, acc_q};
               acc_d      = '0;
               in_num_d   = 1'b0;
               seen_dot_d = 1'b0;
               frac_d     = '0;
               state_d    = (idx_q == len_q) ? ST_FINISH : ST_SCAN;
            end else begin
               acc_d  = mac_res;
               frac_d = frac_q + 1'b1;
               if (mac_sat) err_d[ERR_OVF] = 1'b1;
            end
         end
         ST_FINISH: begin
            out_len_d = out_idx_q;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A full output store drops the entry but scanning carries on
      if (wr_req) begin
         if (out_idx_q == LW'(DEPTH)) begin
            err_d[ERR_FULL] = 1'b1;
         end else begin
            wrEn      = 1'b1;
            out_idx_d = out_idx_q + 1'b1;
         end
      end
   end

   // State and datapath registers; reset aborts any run in progress
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         out_idx_q  <= '0;
         len_q      <= '0;
         out_len_q  <= '0;
         acc_q      <= '0;
         in_num_q   <= 1'b0;
         seen_dot_q <= 1'b0;
         frac_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         out_idx_q  <= out_idx_d;
         len_q      <= len_d;
         out_len_q  <= out_len_d;
         acc_q      <= acc_d;
         in_num_q   <= in_num_d;
         seen_dot_q <= seen_dot_d;
         frac_q     <= frac_d;
         err_q      <= err_d;
      end
   end

endmodule
